// File: rtl/memory_dumper_if.sv
// Memory-read and output-stream bundle for memory_dumper.
//   mem_addr / mem_read  : read request toward the unified memory read port
//   mem_read_data        : memory data, valid one cycle after mem_read is sampled
//   out_data / out_valid / out_last / out_ready : valid/ready word stream to the consumer
// The master modport is the dumper side; the slave modport is the memory plus consumer side.
interface memory_dumper_if #(
   parameter int WORD_SIZE     = 16,
   parameter int MEM_ADDR_SIZE = 8
);
   logic [MEM_ADDR_SIZE-1:0] mem_addr;
   logic                     mem_read;
   logic [WORD_SIZE-1:0]     mem_read_data;
   logic [WORD_SIZE-1:0]     out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_last;

   modport master (
      output mem_addr,
      output mem_read,
      input  mem_read_data,
      output out_data,
      output out_valid,
      input  out_ready,
      output out_last
   );

   modport slave (
      input  mem_addr,
      input  mem_read,
      output mem_read_data,
      input  out_data,
      input  out_valid,
      output out_ready,
      input  out_last
   );
endinterface

// File: rtl/memory_dumper.sv
// Reads a contiguous range of memory and streams each word out, ascending address order,
// one word at a time over a valid/ready interface.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   start_dump     : dump request, sampled only in IDLE or DONE
//   dump_base      : first address, latched on start
//   dump_count     : word count, latched on start and clamped to MEM_SIZE
//   dump_busy      : high while a dump is in progress (ISSUE/CAPTURE/SEND)
//   dump_complete  : high in DONE until the next start or reset
//   bus            : memory read port and output stream (memory_dumper_if.master)
//
// state   | meaning
// IDLE    | after reset, waiting for start_dump
// ISSUE   | read strobe presented, memory samples the address
// CAPTURE | memory data returned, loaded into the output register
// SEND    | out_valid held until the consumer accepts
// DONE    | dump finished, dump_complete high, waiting for a new start
module memory_dumper #(
   parameter int WORD_SIZE     = 16,
   parameter int MEM_ADDR_SIZE = 8,
   parameter int MEM_SIZE      = 256
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start_dump,
   input  logic [MEM_ADDR_SIZE-1:0] dump_base,
   input  logic [MEM_ADDR_SIZE:0]   dump_count,
   output logic                     dump_busy,
   output logic                     dump_complete,
   memory_dumper_if.master          bus
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] SEND    = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   localparam logic [MEM_ADDR_SIZE:0]   MEM_SIZE_C = (MEM_ADDR_SIZE+1)'(MEM_SIZE);
   localparam logic [MEM_ADDR_SIZE-1:0] LAST_ADDR  = MEM_ADDR_SIZE'(MEM_SIZE - 1);

   logic [2:0]               state;
   logic [MEM_ADDR_SIZE:0]   remaining;
   logic [MEM_ADDR_SIZE-1:0] addr;
   logic                     rd;
   logic [WORD_SIZE-1:0]     data;
   logic                     valid;
   logic                     last;

   logic [MEM_ADDR_SIZE:0]   count_clamped;
   logic [MEM_ADDR_SIZE-1:0] addr_next;

   assign count_clamped = (dump_count > MEM_SIZE_C) ? MEM_SIZE_C : dump_count;
   // Wrap modulo MEM_SIZE, which need not be a power of two.
   assign addr_next     = (addr == LAST_ADDR) ? '0 : addr + MEM_ADDR_SIZE'(1);

   assign bus.mem_addr  = addr;
   assign bus.mem_read  = rd;
   assign bus.out_data  = data;
   assign bus.out_valid = valid;
   assign bus.out_last  = last;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         remaining     <= '0;
         addr          <= '0;
         rd            <= 1'b0;
         data          <= '0;
         valid         <= 1'b0;
         last          <= 1'b0;
         dump_busy     <= 1'b0;
         dump_complete <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_dump) begin
                  dump_complete <= 1'b0;
                  remaining     <= count_clamped;
                  if (count_clamped == '0) begin
                     state     <= DONE;
                     dump_busy <= 1'b0;
                  end else begin
                     addr      <= dump_base;
                     rd        <= 1'b1;
                     dump_busy <= 1'b1;
                     state     <= ISSUE;
                  end
               end else if (state == DONE && !dump_complete) begin
                  // Empty dump: completion is reported one cycle after the start.
                  dump_complete <= 1'b1;
               end
            end
            ISSUE: begin
               rd    <= 1'b0;
               state <= CAPTURE;
            end
            CAPTURE: begin
               data  <= bus.mem_read_data;
               valid <= 1'b1;
               last  <= (remaining == (MEM_ADDR_SIZE+1)'(1));
               state <= SEND;
            end
            SEND: begin
               if (bus.out_ready) begin
                  valid     <= 1'b0;
                  remaining <= remaining - (MEM_ADDR_SIZE+1)'(1);
                  if (remaining == (MEM_ADDR_SIZE+1)'(1)) begin
                     last          <= 1'b0;
                     dump_complete <= 1'b1;
                     dump_busy     <= 1'b0;
                     state         <= DONE;
                  end else begin
                     addr  <= addr_next;
                     rd    <= 1'b1;
                     state <= ISSUE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               rd        <= 1'b0;
               valid     <= 1'b0;
               last      <= 1'b0;
               dump_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_dumper.sv
module tb_memory_dumper;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start_dump = 1'b0;
   logic [7:0] dump_base = 8'h00;
   logic [8:0] dump_count = 9'd0;
   logic       dump_busy;
   logic       dump_complete;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   memory_dumper_if #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8)) bus ();

   memory_dumper #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8), .MEM_SIZE(256)) dut (
      .clock         (clock),
      .reset         (reset),
      .start_dump    (start_dump),
      .dump_base     (dump_base),
      .dump_count    (dump_count),
      .dump_busy     (dump_busy),
      .dump_complete (dump_complete),
      .bus           (bus)
   );

   // Memory model: registered read, data valid one cycle after mem_read is sampled.
   logic [15:0] mem [0:255];
   always @(posedge clock) begin
      if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_addr];
   end

   // Consumer: 0 = never ready, 1 = always ready, 2 = ready only after 5 cycles of valid.
   int ready_mode = 0;
   int hold = 0;
   always @(negedge clock) begin
      case (ready_mode)
         0: bus.out_ready <= 1'b0;
         1: bus.out_ready <= 1'b1;
         default: begin
            if (!bus.out_valid) begin
               hold <= 0;
               bus.out_ready <= 1'b0;
            end else if (hold < 5) begin
               hold <= hold + 1;
               bus.out_ready <= 1'b0;
            end else begin
               bus.out_ready <= 1'b1;
            end
         end
      endcase
   end

   // Recorder of handshakes, read addresses and protocol events.
   int          hs_cnt = 0;
   int          rd_cnt = 0;
   int          overlap_cnt = 0;
   int          unstable_cnt = 0;
   logic [15:0] hs_data [0:1023];
   logic        hs_last [0:1023];
   logic [7:0]  rd_log  [0:1023];
   logic        prev_hold = 1'b0;
   logic [15:0] prev_data = 16'h0;
   logic        prev_last = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         prev_hold <= 1'b0;
      end else begin
         if (bus.out_valid && bus.out_ready && hs_cnt < 1024) begin
            hs_data[hs_cnt] <= bus.out_data;
            hs_last[hs_cnt] <= bus.out_last;
            hs_cnt <= hs_cnt + 1;
         end
         if (bus.mem_read && rd_cnt < 1024) begin
            rd_log[rd_cnt] <= bus.mem_addr;
            rd_cnt <= rd_cnt + 1;
         end
         if (bus.mem_read && bus.out_valid) overlap_cnt <= overlap_cnt + 1;
         if (prev_hold && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
            unstable_cnt <= unstable_cnt + 1;
         prev_hold <= bus.out_valid && !bus.out_ready;
         prev_data <= bus.out_data;
         prev_last <= bus.out_last;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Called at a negedge; start is sampled by the following rising edge.
   task automatic do_start(input logic [7:0] b, input logic [8:0] c);
      start_dump = 1'b1;
      dump_base  = b;
      dump_count = c;
      @(negedge clock);
      start_dump = 1'b0;
      dump_base  = 8'h5A;
      dump_count = 9'h0AB;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (!dump_complete && n < budget) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (dump_complete !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: dump_complete=%0b after %0d cycles, required 1", tag, dump_complete, n);
      end
   endtask

   task automatic test_reset;
      tick(3);
      checks++;
      if ({bus.mem_addr, bus.mem_read, bus.out_data, bus.out_valid, bus.out_last} !== 27'h0) begin
         errors++;
         $display("FAIL reset_bus: addr=%h rd=%b data=%h valid=%b last=%b, required all 0",
                  bus.mem_addr, bus.mem_read, bus.out_data, bus.out_valid, bus.out_last);
      end
      checks++;
      if ({dump_busy, dump_complete} !== 2'b00) begin
         errors++;
         $display("FAIL reset_status: busy=%b complete=%b, required 0 0", dump_busy, dump_complete);
      end
      reset = 1'b0;
      tick(2);
      checks++;
      if ({bus.mem_read, bus.out_valid, dump_busy, dump_complete} !== 4'b0000) begin
         errors++;
         $display("FAIL idle_after_reset: rd=%b valid=%b busy=%b complete=%b, required 0",
                  bus.mem_read, bus.out_valid, dump_busy, dump_complete);
      end
   endtask

   task automatic test_basic;
      logic [15:0] exp_d [3] = '{16'h1111, 16'h2222, 16'h3333};
      logic        exp_l [3] = '{1'b0, 1'b0, 1'b1};
      int h0, r0, o0;
      mem[8'h10] = 16'h1111; mem[8'h11] = 16'h2222; mem[8'h12] = 16'h3333;
      ready_mode = 1;
      tick(1);
      h0 = hs_cnt; r0 = rd_cnt; o0 = overlap_cnt;
      do_start(8'h10, 9'd3);
      checks++;
      if ({dump_busy, bus.mem_read, bus.mem_addr} !== {1'b1, 1'b1, 8'h10}) begin
         errors++;
         $display("FAIL basic_issue: busy=%b rd=%b addr=%h, required 1 1 10", dump_busy, bus.mem_read, bus.mem_addr);
      end
      wait_done(40, "basic");
      checks++;
      if (hs_cnt - h0 !== 3) begin
         errors++;
         $display("FAIL basic_count: words=%0d, required 3", hs_cnt - h0);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (hs_data[h0+i] !== exp_d[i] || hs_last[h0+i] !== exp_l[i]) begin
            errors++;
            $display("FAIL basic_word%0d: data=%h last=%b, required %h %b", i, hs_data[h0+i], hs_last[h0+i], exp_d[i], exp_l[i]);
         end
         checks++;
         if (rd_log[r0+i] !== 8'(8'h10 + i)) begin
            errors++;
            $display("FAIL basic_addr%0d: addr=%h, required %h", i, rd_log[r0+i], 8'(8'h10 + i));
         end
      end
      checks++;
      if (overlap_cnt - o0 !== 0) begin
         errors++;
         $display("FAIL basic_overlap: mem_read with out_valid seen %0d times, required 0", overlap_cnt - o0);
      end
      tick(4);
      checks++;
      if ({dump_complete, dump_busy, bus.out_valid} !== 3'b100) begin
         errors++;
         $display("FAIL basic_done_hold: complete=%b busy=%b valid=%b, required 1 0 0", dump_complete, dump_busy, bus.out_valid);
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] exp_d [3] = '{16'h1111, 16'h2222, 16'h3333};
      int h0, r0, u0, t0;
      ready_mode = 2;
      tick(1);
      h0 = hs_cnt; r0 = rd_cnt; u0 = unstable_cnt;
      t0 = 0;
      do_start(8'h10, 9'd3);
      while (!dump_complete && t0 < 100) begin
         @(negedge clock);
         t0++;
      end
      checks++;
      if (dump_complete !== 1'b1 || t0 < 15) begin
         errors++;
         $display("FAIL bp_done: complete=%b after %0d cycles, required 1 after at least 15", dump_complete, t0);
      end
      checks++;
      if (hs_cnt - h0 !== 3 || rd_cnt - r0 !== 3) begin
         errors++;
         $display("FAIL bp_counts: words=%0d reads=%0d, required 3 3", hs_cnt - h0, rd_cnt - r0);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (hs_data[h0+i] !== exp_d[i]) begin
            errors++;
            $display("FAIL bp_word%0d: data=%h, required %h", i, hs_data[h0+i], exp_d[i]);
         end
      end
      checks++;
      if (unstable_cnt - u0 !== 0) begin
         errors++;
         $display("FAIL bp_stable: output changed while stalled %0d times, required 0", unstable_cnt - u0);
      end
   endtask

   task automatic test_wrap;
      logic [7:0]  exp_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      logic [15:0] exp_d [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
      int h0, r0;
      mem[8'hFE] = 16'hAAAA; mem[8'hFF] = 16'hBBBB; mem[8'h00] = 16'hCCCC; mem[8'h01] = 16'hDDDD;
      ready_mode = 1;
      tick(1);
      h0 = hs_cnt; r0 = rd_cnt;
      do_start(8'hFE, 9'd4);
      wait_done(50, "wrap");
      checks++;
      if (hs_cnt - h0 !== 4) begin
         errors++;
         $display("FAIL wrap_count: words=%0d, required 4", hs_cnt - h0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_log[r0+i] !== exp_a[i] || hs_data[h0+i] !== exp_d[i]) begin
            errors++;
            $display("FAIL wrap_%0d: addr=%h data=%h, required %h %h", i, rd_log[r0+i], hs_data[h0+i], exp_a[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_zero_count;
      int h0, r0;
      ready_mode = 1;
      h0 = hs_cnt; r0 = rd_cnt;
      do_start(8'h20, 9'd0);
      checks++;
      if ({dump_complete, dump_busy, bus.mem_read} !== 3'b000) begin
         errors++;
         $display("FAIL zero_cleared: complete=%b busy=%b rd=%b, required 0 0 0", dump_complete, dump_busy, bus.mem_read);
      end
      tick(1);
      checks++;
      if (dump_complete !== 1'b1) begin
         errors++;
         $display("FAIL zero_complete: complete=%b, required 1", dump_complete);
      end
      tick(3);
      checks++;
      if (hs_cnt - h0 !== 0 || rd_cnt - r0 !== 0) begin
         errors++;
         $display("FAIL zero_activity: words=%0d reads=%0d, required 0 0", hs_cnt - h0, rd_cnt - r0);
      end
   endtask

   task automatic test_clamp;
      int h0, r0, bad, lasts;
      for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3 + 16'h0100);
      ready_mode = 1;
      tick(1);
      h0 = hs_cnt; r0 = rd_cnt;
      do_start(8'h00, 9'd300);
      wait_done(1000, "clamp");
      checks++;
      if (hs_cnt - h0 !== 256 || rd_cnt - r0 !== 256) begin
         errors++;
         $display("FAIL clamp_count: words=%0d reads=%0d, required 256 256", hs_cnt - h0, rd_cnt - r0);
      end
      bad = 0; lasts = 0;
      for (int i = 0; i < 256; i++) begin
         if (hs_data[h0+i] !== 16'(i * 3 + 16'h0100)) bad++;
         if (hs_last[h0+i] === 1'b1) lasts++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL clamp_data: %0d wrong words, required 0", bad);
      end
      checks++;
      if (lasts !== 1 || hs_last[h0+255] !== 1'b1) begin
         errors++;
         $display("FAIL clamp_last: last count=%0d final last=%b, required 1 1", lasts, hs_last[h0+255]);
      end
   endtask

   task automatic test_reset_mid;
      int h0, n;
      mem[8'h40] = 16'hA001; mem[8'h41] = 16'hA002; mem[8'h42] = 16'hA003;
      mem[8'h50] = 16'h5151; mem[8'h51] = 16'h5252;
      ready_mode = 2;
      tick(1);
      h0 = hs_cnt;
      do_start(8'h40, 9'd3);
      n = 0;
      while (!(hs_cnt - h0 == 1 && bus.out_valid) && n < 60) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (hs_cnt - h0 !== 1 || bus.out_valid !== 1'b1 || bus.out_data !== 16'hA002) begin
         errors++;
         $display("FAIL rmid_send2: words=%0d valid=%b data=%h, required 1 1 a002", hs_cnt - h0, bus.out_valid, bus.out_data);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.mem_addr, bus.mem_read, bus.out_data, bus.out_valid, bus.out_last} !== 27'h0) begin
         errors++;
         $display("FAIL rmid_async_bus: addr=%h rd=%b data=%h valid=%b last=%b, required all 0",
                  bus.mem_addr, bus.mem_read, bus.out_data, bus.out_valid, bus.out_last);
      end
      checks++;
      if ({dump_busy, dump_complete} !== 2'b00) begin
         errors++;
         $display("FAIL rmid_async_status: busy=%b complete=%b, required 0 0", dump_busy, dump_complete);
      end
      tick(2);
      reset = 1'b0;
      ready_mode = 1;
      tick(1);
      checks++;
      if (hs_cnt - h0 !== 1) begin
         errors++;
         $display("FAIL rmid_dropped: words=%0d, required 1", hs_cnt - h0);
      end
      h0 = hs_cnt;
      do_start(8'h50, 9'd2);
      wait_done(40, "rmid_restart");
      checks++;
      if (hs_cnt - h0 !== 2 || hs_data[h0] !== 16'h5151 || hs_data[h0+1] !== 16'h5252 || hs_last[h0+1] !== 1'b1) begin
         errors++;
         $display("FAIL rmid_restart: words=%0d d0=%h d1=%h last=%b, required 2 5151 5252 1",
                  hs_cnt - h0, hs_data[h0], hs_data[h0+1], hs_last[h0+1]);
      end
   endtask

   task automatic test_start_busy;
      logic [15:0] exp_d [3] = '{16'h6001, 16'h6002, 16'h6003};
      int h0, r0, n;
      mem[8'h60] = 16'h6001; mem[8'h61] = 16'h6002; mem[8'h62] = 16'h6003;
      mem[8'h70] = 16'h7777;
      ready_mode = 2;
      tick(1);
      h0 = hs_cnt; r0 = rd_cnt;
      do_start(8'h60, 9'd3);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      do_start(8'h70, 9'd5);
      checks++;
      if ({dump_busy, bus.out_valid, bus.out_data} !== {1'b1, 1'b1, 16'h6001}) begin
         errors++;
         $display("FAIL busy_ignore_now: busy=%b valid=%b data=%h, required 1 1 6001", dump_busy, bus.out_valid, bus.out_data);
      end
      wait_done(100, "busy_ignore");
      checks++;
      if (hs_cnt - h0 !== 3 || rd_cnt - r0 !== 3) begin
         errors++;
         $display("FAIL busy_ignore_count: words=%0d reads=%0d, required 3 3", hs_cnt - h0, rd_cnt - r0);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (hs_data[h0+i] !== exp_d[i] || rd_log[r0+i] !== 8'(8'h60 + i)) begin
            errors++;
            $display("FAIL busy_ignore_%0d: data=%h addr=%h, required %h %h", i, hs_data[h0+i], rd_log[r0+i], exp_d[i], 8'(8'h60 + i));
         end
      end
   endtask

   task automatic test_restart_done;
      int h0;
      mem[8'h33] = 16'hBEEF;
      ready_mode = 1;
      tick(1);
      h0 = hs_cnt;
      do_start(8'h33, 9'd1);
      checks++;
      if ({dump_complete, dump_busy, bus.mem_addr} !== {1'b0, 1'b1, 8'h33}) begin
         errors++;
         $display("FAIL restart_start: complete=%b busy=%b addr=%h, required 0 1 33", dump_complete, dump_busy, bus.mem_addr);
      end
      wait_done(30, "restart");
      checks++;
      if (hs_cnt - h0 !== 1 || hs_data[h0] !== 16'hBEEF || hs_last[h0] !== 1'b1) begin
         errors++;
         $display("FAIL restart_word: words=%0d data=%h last=%b, required 1 beef 1", hs_cnt - h0, hs_data[h0], hs_last[h0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_count();
      test_clamp();
      test_reset_mid();
      test_start_busy();
      test_restart_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
